// File: rtl/store_pkg.sv
// Shared types and constants for the store alignment buffer.
// Optional big-endian lane mapping is selected with the SAB_BIG_ENDIAN_EN macro.
package store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } store_size_t;

    // Widest byte address a queued entry can carry; the top narrows it to ADDR_W.
    localparam int ENTRY_ADDR_W = 32;

    localparam logic [3:0] BE_ALL  = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] addr;
        logic [31:0]             wdata;
        logic [3:0]              be;
    } store_entry_t;

endpackage

// File: rtl/store_lane_pack.sv
// Combinational store narrowing: replicates store data across the 32-bit lanes,
// builds byte enables and flags misaligned/illegal sizes. SAB_BIG_ENDIAN_EN flips lane order.
module store_lane_pack
    import store_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misaligned
);

    always_comb begin
        wdata      = data;
        be         = BE_NONE;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                wdata = {4{data[7:0]}};
`ifdef SAB_BIG_ENDIAN_EN
                be    = 4'b1000 >> addr_lo;
`else
                be    = 4'b0001 << addr_lo;
`endif
            end
            SZ_HALF: begin
                wdata      = {2{data[15:0]}};
                misaligned = addr_lo[0];
`ifdef SAB_BIG_ENDIAN_EN
                be         = addr_lo[1] ? 4'b0011 : 4'b1100;
`else
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
`endif
            end
            SZ_WORD: begin
                wdata      = data;
                be         = BE_ALL;
                misaligned = (addr_lo != 2'b00);
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_align_buffer.sv
// Store alignment buffer: packs CPU stores onto memory byte lanes and queues them in a
// DEPTH-entry FIFO drained over valid/ready. Lane order follows SAB_BIG_ENDIAN_EN (see store_lane_pack).
module store_align_buffer
    import store_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [31:0]              st_data,
    input  logic [1:0]               st_size,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    output logic                     misalign_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    store_entry_t          slots [DEPTH];
    store_entry_t          new_entry;
    store_entry_t          head;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic                  err_q;

    logic [31:0]           pack_wdata;
    logic [3:0]            pack_be;
    logic                  pack_misaligned;
    logic [ADDR_W-1:0]     word_addr;

    logic                  full;
    logic                  empty;
    logic                  accept;
    logic                  enq;
    logic                  deq;

    store_lane_pack u_pack (
        .size       (st_size),
        .addr_lo    (st_addr[1:0]),
        .data       (st_data),
        .wdata      (pack_wdata),
        .be         (pack_be),
        .misaligned (pack_misaligned)
    );

    assign word_addr = {st_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        new_entry       = '0;
        new_entry.addr  = ENTRY_ADDR_W'(word_addr);
        new_entry.wdata = pack_wdata;
        new_entry.be    = pack_be;
    end

    // Full blocks enqueue even when the head drains this cycle: no pass-through on full.
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign st_ready = !full;
    assign accept   = st_valid && st_ready;
    assign enq      = accept && !pack_misaligned;
    assign deq      = !empty && mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else begin
            err_q <= accept && pack_misaligned;
            if (enq) begin
                slots[wr_ptr] <= new_entry;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Head is read straight from storage, so mem_* holds while the memory stalls.
    assign head         = slots[rd_ptr];
    assign mem_valid    = !empty;
    assign mem_addr     = ADDR_W'(head.addr);
    assign mem_wdata    = head.wdata;
    assign mem_be       = head.be;
    assign misalign_err = err_q;
    assign count        = count_q;

endmodule
